if_id_reg: RTL and testbench
============================

# if_id_reg

IF/ID pipeline register of the five-stage MIPS core, directly downstream of the hazard detection unit. It captures the fetched instruction and its PC+4 each cycle, holds them when the hazard unit requests a load-use stall, and inserts a bubble when a taken branch or jump flushes the fetch slot. It also presents the decoded rs/rt/rd fields, which the hazard unit and the register file consume. Saturating stall and flush event counters support performance debug.

## Interface
- CNT_W, 16, width of the stall and flush event counters
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset; asynchronous, active-low
- start_i  in  1  pipeline run enable; 0 = IDLE, 1 = RUN
- pc_i  in  32  PC+4 from the IF stage
- inst_i  in  32  instruction word from instruction memory
- write_i  in  1  IF/ID write enable from the hazard unit; 1 = load, 0 = hold (stall)
- flush_i  in  1  taken branch or jump resolved in ID; replace the slot with a bubble
- pc_o  out  32  registered PC+4
- inst_o  out  32  registered instruction
- rs_o  out  5  inst_o[25:21]
- rt_o  out  5  inst_o[20:16]
- rd_o  out  5  inst_o[15:11]
- valid_o  out  1  slot holds a real instruction; 0 = bubble
- stall_cnt_o  out  CNT_W  count of stalled RUN cycles, saturating
- flush_cnt_o  out  CNT_W  count of flushed RUN cycles, saturating

## Operation
- States: IDLE and RUN. Reset enters IDLE. IDLE goes to RUN on a clock edge with start_i=1. RUN returns to IDLE on a clock edge with start_i=0.
- In IDLE, all registers hold their values. Counters do not change. write_i and flush_i are ignored.
- In RUN, the update uses the following priority, evaluated at each rising edge:
  1. flush_i=1: inst_o<=32'h0000_0000 (sll $0,$0,0 NOP), pc_o<=pc_i, valid_o<=0, flush_cnt_o+=1. Flush takes priority over a simultaneous write_i=0.
  2. write_i=0: pc_o, inst_o and valid_o hold; stall_cnt_o+=1.
  3. Otherwise: pc_o<=pc_i, inst_o<=inst_i, valid_o<=1.
- In the flush-and-stall case, only flush_cnt_o increments.
- Counters saturate at 2^CNT_W-1 and never wrap.
- rs_o, rt_o and rd_o are pure combinational slices of the inst_o register. They reflect the held value during a stall and are 0 for a bubble.
- Reset (rst_i=0) takes effect immediately at any time, including mid-stall or during a flush: pc_o=0, inst_o=0, valid_o=0, rs_o/rt_o/rd_o=0, both counters=0, state=IDLE.

## Timing
- Latency is one cycle: values presented on pc_i/inst_i at edge N appear on pc_o/inst_o after edge N when loaded.
- The first load happens on the first edge at which the state is already RUN. The edge that moves IDLE to RUN does not load.
- write_i and flush_i are sampled only at the rising edge. They are combinational inputs and must be settled before the edge. No handshake exists beyond this.
- A stall of k consecutive cycles holds the outputs for exactly k edges and adds k to stall_cnt_o.
- There is no combinational path from any input to any output. The only logic between registers and outputs is the field slicing.
- Release of rst_i is asynchronous. The first state update occurs on the first rising edge after rst_i rises.

## Test plan
- Reset mid-run: load inst 0x8C220004, then assert rst_i=0 between edges -> all outputs 0 immediately, without waiting for a clock edge, and state returns to IDLE.
- Normal flow: start_i=1, feed pc_i=4/8/12 with inst 0x8C220004/0x00431020/0xAC230000 -> one cycle later outputs match in order, rs_o=1/2/1, rt_o=2/3/3, valid_o=1.
- Load-use stall: write_i=0 for 2 cycles while inst_i changes -> inst_o stays 0x00431020, pc_o=8, stall_cnt_o=2, then the next value loads after write_i returns to 1.
- Flush: flush_i=1 with pc_i=16 and inst_i=0x1000FFFF -> inst_o=0, pc_o=16, valid_o=0, rs_o=rt_o=0, flush_cnt_o=1.
- Flush and stall together: flush_i=1 with write_i=0 -> bubble inserted, flush_cnt_o+=1, stall_cnt_o unchanged.
- Saturation and IDLE: with CNT_W=2, stall for 5 cycles -> stall_cnt_o=3. Then start_i=0 with write_i=0 -> no change to any output or counter.

Source files
------------

// File: rtl/if_id_reg_if.sv
// IF/ID register bundle: fetch-side inputs and the registered slot it presents
// Ports: start/pc/inst/write/flush in; pc/inst/rs/rt/rd/valid/counters out
interface if_id_reg_if #(
   parameter int CNT_W = 16
);
   logic             start_i;
   logic [31:0]      pc_i;
   logic [31:0]      inst_i;
   logic             write_i;
   logic             flush_i;
   logic [31:0]      pc_o;
   logic [31:0]      inst_o;
   logic [4:0]       rs_o;
   logic [4:0]       rt_o;
   logic [4:0]       rd_o;
   logic             valid_o;
   logic [CNT_W-1:0] stall_cnt_o;
   logic [CNT_W-1:0] flush_cnt_o;

   // upstream side: IF stage plus hazard unit, consumes the slot
   modport master (
      output start_i, pc_i, inst_i, write_i, flush_i,
      input  pc_o, inst_o, rs_o, rt_o, rd_o, valid_o,
      input  stall_cnt_o, flush_cnt_o
   );

   // the pipeline register itself
   modport slave (
      input  start_i, pc_i, inst_i, write_i, flush_i,
      output pc_o, inst_o, rs_o, rt_o, rd_o, valid_o,
      output stall_cnt_o, flush_cnt_o
   );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load / stall-hold / flush-bubble, saturating counters
// Ports: clk_i, rst_i (async active-low), bus (if_id_reg_if.slave)
module if_id_reg #(
   parameter int CNT_W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   if_id_reg_if.slave   bus
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_e           state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      inst_q, inst_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      inst_d      = inst_q;
      valid_d     = valid_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      unique case (state_q)
         IDLE: begin
            // the edge entering RUN only arms the pipeline, it loads nothing
            if (bus.start_i) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (!bus.start_i) begin
               // stopping freezes the slot on this same edge
               state_d = IDLE;
            end else if (bus.flush_i) begin
               // flush wins over a simultaneous stall; only flushes count
               pc_d    = bus.pc_i;
               inst_d  = 32'h0000_0000;
               valid_d = 1'b0;
               if (flush_cnt_q != CNT_MAX) begin
                  flush_cnt_d = flush_cnt_q + CNT_ONE;
               end
            end else if (!bus.write_i) begin
               if (stall_cnt_q != CNT_MAX) begin
                  stall_cnt_d = stall_cnt_q + CNT_ONE;
               end
            end else begin
               pc_d    = bus.pc_i;
               inst_d  = bus.inst_i;
               valid_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= IDLE;
         pc_q        <= '0;
         inst_q      <= '0;
         valid_q     <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         inst_q      <= inst_d;
         valid_q     <= valid_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign bus.pc_o        = pc_q;
   assign bus.inst_o      = inst_q;
   assign bus.valid_o     = valid_q;
   assign bus.stall_cnt_o = stall_cnt_q;
   assign bus.flush_cnt_o = flush_cnt_q;

   // register-specifier fields feed the hazard unit and register file
   assign bus.rs_o = inst_q[25:21];
   assign bus.rt_o = inst_q[20:16];
   assign bus.rd_o = inst_q[15:11];

endmodule

// File: tb/tb_if_id_reg.sv
// Bench for if_id_reg: 16-bit and 2-bit counter instances, same stimulus
// Behavioural model compared every cycle plus hand-computed literal checks
module tb_if_id_reg;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   if_id_reg_if #(.CNT_W(16)) b16();
   if_id_reg_if #(.CNT_W(2))  b2();

   if_id_reg #(.CNT_W(16)) u16 (.clk_i(clk), .rst_i(rst_n), .bus(b16.slave));
   if_id_reg #(.CNT_W(2))  u2  (.clk_i(clk), .rst_i(rst_n), .bus(b2.slave));

   // model state: plain counts, saturation applied when compared
   bit          m_run;
   logic [31:0] m_pc, m_inst;
   bit          m_valid;
   int          m_stalls, m_flushes;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] sat(int n, int w);
      int mx;
      mx = (1 << w) - 1;
      return (n > mx) ? mx : n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_run = 0; m_pc = 0; m_inst = 0; m_valid = 0;
         m_stalls = 0; m_flushes = 0;
      end else if (!m_run) begin
         if (b16.start_i) m_run = 1;
      end else if (!b16.start_i) begin
         m_run = 0;
      end else if (b16.flush_i) begin
         m_pc = b16.pc_i; m_inst = 0; m_valid = 0; m_flushes++;
      end else if (!b16.write_i) begin
         m_stalls++;
      end else begin
         m_pc = b16.pc_i; m_inst = b16.inst_i; m_valid = 1;
      end
   end

   always @(posedge clk) begin
      #1;
      chk("m16 pc", b16.pc_o, m_pc);
      chk("m16 inst", b16.inst_o, m_inst);
      chk("m16 rs", 32'(b16.rs_o), (m_inst >> 21) & 31);
      chk("m16 rt", 32'(b16.rt_o), (m_inst >> 16) & 31);
      chk("m16 rd", 32'(b16.rd_o), (m_inst >> 11) & 31);
      chk("m16 valid", 32'(b16.valid_o), 32'(m_valid));
      chk("m16 stall", 32'(b16.stall_cnt_o), sat(m_stalls, 16));
      chk("m16 flush", 32'(b16.flush_cnt_o), sat(m_flushes, 16));
      chk("m2 inst", b2.inst_o, m_inst);
      chk("m2 pc", b2.pc_o, m_pc);
      chk("m2 stall", 32'(b2.stall_cnt_o), sat(m_stalls, 2));
      chk("m2 flush", 32'(b2.flush_cnt_o), sat(m_flushes, 2));
   end

   task automatic drive(bit st, logic [31:0] pc, logic [31:0] inst,
                        bit wr, bit fl);
      b16.start_i = st; b16.pc_i = pc; b16.inst_i = inst;
      b16.write_i = wr; b16.flush_i = fl;
      b2.start_i = st;  b2.pc_i = pc;  b2.inst_i = inst;
      b2.write_i = wr;  b2.flush_i = fl;
   endtask

   // drive before an edge, return 2 ns after it
   task automatic cyc(bit st, logic [31:0] pc, logic [31:0] inst,
                      bit wr, bit fl);
      drive(st, pc, inst, wr, fl);
      @(posedge clk);
      #2;
   endtask

   task automatic all_zero(string nm);
      chk({nm, " pc"}, b16.pc_o, 0);
      chk({nm, " inst"}, b16.inst_o, 0);
      chk({nm, " fields"}, {17'd0, b16.rs_o, b16.rt_o, b16.rd_o}, 0);
      chk({nm, " valid"}, 32'(b16.valid_o), 0);
      chk({nm, " cnts"}, {b16.stall_cnt_o, b16.flush_cnt_o}, 0);
   endtask

   initial begin
      drive(0, 0, 0, 1, 0);
      #1;
      all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // reset mid-run
      cyc(1, 32'd4, 32'h8C22_0004, 1, 0);
      chk("arm no load", b16.inst_o, 0);
      cyc(1, 32'd4, 32'h8C22_0004, 1, 0);
      chk("first load", b16.inst_o, 32'h8C22_0004);
      #1 rst_n = 1'b0;
      #1 all_zero("async rst");
      @(negedge clk);
      rst_n = 1'b1;
      cyc(0, 32'd4, 32'h8C22_0004, 1, 0);
      chk("idle after rst", b16.inst_o, 0);

      // normal flow
      cyc(1, 32'd0, 32'h0, 1, 0);
      cyc(1, 32'd4, 32'h8C22_0004, 1, 0);
      chk("n1 pc", b16.pc_o, 4);
      chk("n1 rs/rt", {b16.rs_o, b16.rt_o}, {5'd1, 5'd2});
      cyc(1, 32'd8, 32'h0043_1020, 1, 0);
      chk("n2 rs/rt/rd", {b16.rs_o, b16.rt_o, b16.rd_o}, {5'd2, 5'd3, 5'd2});
      chk("n2 valid", 32'(b16.valid_o), 1);

      // load-use stall
      cyc(1, 32'd12, 32'hAC23_0000, 0, 0);
      cyc(1, 32'd16, 32'h1234_5678, 0, 0);
      chk("stall inst", b16.inst_o, 32'h0043_1020);
      chk("stall pc", b16.pc_o, 8);
      chk("stall cnt", 32'(b16.stall_cnt_o), 2);
      cyc(1, 32'd12, 32'hAC23_0000, 1, 0);
      chk("n3 inst", b16.inst_o, 32'hAC23_0000);
      chk("n3 rs/rt", {b16.rs_o, b16.rt_o}, {5'd1, 5'd3});

      // flush
      cyc(1, 32'd16, 32'h1000_FFFF, 1, 1);
      chk("fl inst", b16.inst_o, 0);
      chk("fl pc", b16.pc_o, 16);
      chk("fl valid", 32'(b16.valid_o), 0);
      chk("fl cnt", 32'(b16.flush_cnt_o), 1);

      // flush and stall together
      cyc(1, 32'd20, 32'h0043_1020, 0, 1);
      chk("fs pc", b16.pc_o, 20);
      chk("fs cnts", {b16.stall_cnt_o, b16.flush_cnt_o}, {16'd2, 16'd2});
      cyc(1, 32'd24, 32'h8C22_0004, 1, 0);
      chk("after fs", b16.inst_o, 32'h8C22_0004);

      // saturation on the 2-bit instance
      for (int i = 0; i < 5; i++) cyc(1, 32'(100 + i), 32'hFFFF_FFFF, 0, 0);
      chk("sat2", 32'(b2.stall_cnt_o), 3);
      chk("sat16", 32'(b16.stall_cnt_o), 7);
      chk("sat flush2", 32'(b2.flush_cnt_o), 2);

      // stop, then IDLE ignores write/flush
      cyc(0, 32'd200, 32'hDEAD_BEEF, 0, 0);
      chk("stop hold", b2.inst_o, 32'h8C22_0004);
      chk("stop stall16", 32'(b16.stall_cnt_o), 7);
      cyc(0, 32'd204, 32'hDEAD_BEEF, 1, 0);
      cyc(0, 32'd208, 32'hDEAD_BEEF, 0, 1);
      chk("idle pc", b16.pc_o, 24);
      chk("idle flush", 32'(b16.flush_cnt_o), 2);

      // restart: arm edge, then load
      cyc(1, 32'd28, 32'h0043_1020, 1, 0);
      chk("rearm hold", b16.pc_o, 24);
      cyc(1, 32'd32, 32'h0043_1020, 1, 0);
      chk("reload pc", b16.pc_o, 32);

      // flush saturation on the 2-bit instance
      for (int i = 0; i < 3; i++) cyc(1, 32'(40 + i), 32'h0, 1, 1);
      chk("fsat2", 32'(b2.flush_cnt_o), 3);
      chk("fsat16", 32'(b16.flush_cnt_o), 5);

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
